// File: rtl/mac_pkg.sv
// Shared constants for the MAC column and its output drain: default widths,
// requantisation shift width, activation limits and the saturation counter width.
package mac_pkg;

    localparam int N_DEF         = 8;
    localparam int SUM_WIDTH_DEF = (N_DEF * 2) + 4;
    localparam int SHIFT_W       = 4;
    localparam int SAT_CNT_W     = 8;

    function automatic int act_max(input int w);
        return (2 ** (w - 1)) - 1;
    endfunction

    function automatic int act_min(input int w);
        return -(2 ** (w - 1));
    endfunction

    localparam int ACT_MAX = act_max(N_DEF);
    localparam int ACT_MIN = act_min(N_DEF);

endpackage

// File: rtl/drain_fifo.sv
// Synchronous show-ahead FIFO holding quantised activations for mac_drain.
// Head reads as zero while empty so no stale word is ever presented.
module drain_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a write when the head leaves on the same edge.
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // NOTE: storage has no reset; validity is tracked by count, and empty masks dout.
    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mac_drain.sv
// Output drain of the MAC column: bias add, rounding shift, saturation, output FIFO.
// Define MAC_DRAIN_RELU_EN to clamp negative results to zero before saturation.
module mac_drain
    import mac_pkg::*;
#(
    parameter int n         = N_DEF,
    parameter int SUM_WIDTH = (n * 2) + 4,
    parameter int DEPTH     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        acc_valid,
    input  logic signed [SUM_WIDTH-1:0] acc_in,
    output logic                        in_ready,
    input  logic signed [SUM_WIDTH-1:0] bias,
    input  logic [SHIFT_W-1:0]          shift,
    output logic                        out_valid,
    output logic signed [n-1:0]         out_data,
    input  logic                        out_ready,
    output logic [SAT_CNT_W-1:0]        sat_cnt
);

    localparam int RW = SUM_WIDTH + 2;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic signed [RW-1:0] MAX_R = RW'(act_max(n));
    localparam logic signed [RW-1:0] MIN_R = RW'(act_min(n));

    logic                      a_valid;
    logic signed [SUM_WIDTH:0] a_sum;
    logic [SHIFT_W-1:0]        a_shift;
    logic [CW-1:0]             fifo_count;
    logic                      fifo_empty;
    logic [CW:0]               occupancy;
    logic                      accept;

    logic [RW-1:0]             rnd;
    logic signed [RW-1:0]      biased;
    logic signed [RW-1:0]      shifted;
    logic signed [RW-1:0]      r;
    logic [n-1:0]              q;
    logic                      clip;

    // Stage A plus FIFO never exceeds DEPTH, so stage A can always drain next edge.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, a_valid};
    assign in_ready  = !clr && (occupancy < (CW + 1)'(DEPTH));
    assign accept    = acc_valid && in_ready;
    assign out_valid = !fifo_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_valid <= 1'b0;
            a_sum   <= '0;
            a_shift <= '0;
        end else if (clr) begin
            a_valid <= 1'b0;
        end else begin
            a_valid <= accept;
            if (accept) begin
                a_sum   <= {acc_in[SUM_WIDTH-1], acc_in} + {bias[SUM_WIDTH-1], bias};
                a_shift <= shift;
            end
        end
    end

    // NOTE: every variable gets its default before any branch, so no latch can form.
    always_comb begin
        rnd     = (RW'(1) << a_shift) >> 1;
        biased  = $signed({a_sum[SUM_WIDTH], a_sum}) + $signed(rnd);
        shifted = biased >>> a_shift;
        r       = shifted;
`ifdef MAC_DRAIN_RELU_EN
        if (shifted < 0) r = '0;
`endif
        clip = 1'b0;
        q    = r[n-1:0];
        if (r > MAX_R) begin
            clip = 1'b1;
            q    = MAX_R[n-1:0];
        end else if (r < MIN_R) begin
            clip = 1'b1;
            q    = MIN_R[n-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_cnt <= '0;
        end else if (clr) begin
            sat_cnt <= '0;
        end else if (a_valid && clip && (sat_cnt != '1)) begin
            sat_cnt <= sat_cnt + SAT_CNT_W'(1);
        end
    end

    drain_fifo #(
        .WIDTH (n),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (a_valid),
        .din   (q),
        .pop   (out_valid && out_ready),
        .dout  (out_data),
        .count (fifo_count),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_mac_drain.sv
// Self-checking bench for mac_drain: directed vector table, back-pressure, clear,
// saturation counter, async reset and a randomized run against a queue model.
module tb_mac_drain;
    import mac_pkg::*;

    localparam int n     = 8;
    localparam int SW    = 20;
    localparam int DEPTH = 4;
    localparam longint HI = ACT_MAX;
    localparam longint LO = ACT_MIN;
`ifdef MAC_DRAIN_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 clr;
    logic                 acc_valid;
    logic signed [SW-1:0] acc_in;
    logic                 in_ready;
    logic signed [SW-1:0] bias;
    logic [3:0]           shift;
    logic                 out_valid;
    logic signed [n-1:0]  out_data;
    logic                 out_ready;
    logic [7:0]           sat_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        longint acc;
        longint b;
        int     sh;
        longint exp_data;
        int     exp_sat;
    } vec_t;

    vec_t vecs[7];

    mac_drain #(.n(n), .SUM_WIDTH(SW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .acc_valid (acc_valid),
        .acc_in    (acc_in),
        .in_ready  (in_ready),
        .bias      (bias),
        .shift     (shift),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sat_cnt   (sat_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic signed [63:0] act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Floor-division reference for round-half-up requantisation.
    function automatic longint model(input longint acc, input longint b, input int sh,
                                     output bit clip);
        longint s, d, v, q;
        s = acc + b;
        d = longint'(1) << sh;
        v = s + ((sh > 0) ? d / 2 : 0);
        q = v / d;
        if ((v % d != 0) && (v < 0)) q = q - 1;
        if (RELU && q < 0) q = 0;
        clip = 1'b0;
        if (q > HI) begin
            q = HI;
            clip = 1'b1;
        end else if (q < LO) begin
            q = LO;
            clip = 1'b1;
        end
        return q;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_clr();
        clr       = 1'b1;
        acc_valid = 1'b0;
        tick();
        clr = 1'b0;
    endtask

    task automatic run_vec(input string name, input longint acc, input longint b, input int sh,
                           input longint exp, input int exp_sat);
        out_ready = 1'b1;
        acc_valid = 1'b1;
        acc_in    = SW'(acc);
        bias      = SW'(b);
        shift     = 4'(sh);
        #1 check({name, ".in_ready"}, in_ready, 1);
        tick();
        acc_valid = 1'b0;
        #1 check({name, ".not_yet"}, out_valid, 0);
        tick();
        check({name, ".valid"}, out_valid, 1);
        check({name, ".data"}, out_data, exp);
        check({name, ".sat"}, sat_cnt, exp_sat);
        tick();
        check({name, ".popped"}, out_valid, 0);
    endtask

    initial begin
        int     exp_rdy[6];
        longint q[$];
        longint e;
        bit     cl;
        int     exp_sat;
        int     guard;
        bit     hold;
        logic signed [n-1:0] prev_data;
        int     a, b, s;

        rst = 1'b0; clr = 1'b0; acc_valid = 1'b0; out_ready = 1'b0;
        acc_in = '0; bias = '0; shift = '0;

        #12;
        check("reset.out_valid", out_valid, 0);
        check("reset.out_data", out_data, 0);
        check("reset.sat_cnt", sat_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        #1 check("reset.in_ready", in_ready, 1);

        vecs[0] = '{200, -8, 2, 48, 0};
        vecs[1] = '{-6, 0, 2, RELU ? 0 : -1, 0};
        vecs[2] = '{-500, 0, 0, RELU ? 0 : -128, RELU ? 0 : 1};
        vecs[3] = '{1000, 24, 3, 127, 1};
        vecs[4] = '{7, 0, 1, 4, 0};
        vecs[5] = '{-7, 0, 1, RELU ? 0 : -3, 0};
        vecs[6] = '{300000, 0, 15, 9, 0};
        for (int i = 0; i < 7; i++) begin
            do_clr();
            run_vec($sformatf("vec%0d", i), vecs[i].acc, vecs[i].b, vecs[i].sh,
                    vecs[i].exp_data, vecs[i].exp_sat);
        end

        // Back-pressure: only DEPTH inputs fit while the consumer stalls.
        do_clr();
        out_ready = 1'b0;
        exp_rdy = '{1, 1, 1, 1, 0, 0};
        for (int i = 0; i < 6; i++) begin
            acc_valid = 1'b1;
            acc_in    = SW'(4 * (i + 1));
            bias      = '0;
            shift     = 4'd2;
            #1 check($sformatf("bp.in_ready%0d", i), in_ready, exp_rdy[i]);
            tick();
        end
        acc_valid = 1'b0;
        #1 check("bp.full_ready", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            check("bp.hold_valid", out_valid, 1);
            check("bp.hold_data", out_data, 1);
            tick();
        end
        out_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            check($sformatf("bp.out%0d", j), out_data, j);
            tick();
            if (j == 1) check("bp.ready_back", in_ready, 1);
        end
        check("bp.empty", out_valid, 0);

        // Clear with two entries queued and an input offered in the same cycle.
        do_clr();
        out_ready = 1'b0;
        acc_valid = 1'b1; acc_in = SW'(100000); bias = '0; shift = 4'd0;
        tick();
        acc_in = SW'(40); shift = 4'd2;
        tick();
        acc_valid = 1'b0;
        tick();
        check("clr.pre_valid", out_valid, 1);
        check("clr.pre_sat", sat_cnt, 1);
        clr = 1'b1; acc_valid = 1'b1; acc_in = SW'(12); shift = 4'd2;
        #1 check("clr.in_ready", in_ready, 0);
        tick();
        clr = 1'b0; acc_valid = 1'b0;
        #1;
        check("clr.out_valid", out_valid, 0);
        check("clr.out_data", out_data, 0);
        check("clr.sat", sat_cnt, 0);
        tick();
        check("clr.not_accepted", out_valid, 0);
        run_vec("clr.after", 200, -8, 2, 48, 0);

        // Saturation counter sticks at its maximum.
        do_clr();
        out_ready = 1'b1; acc_valid = 1'b1; acc_in = SW'(100000); bias = '0; shift = 4'd0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 9)   check("sat.count9", sat_cnt, 9);
            if (i == 299) check("sat.out_data", out_data, 127);
        end
        acc_valid = 1'b0;
        tick();
        tick();
        check("sat.hold255", sat_cnt, 255);

        // Asynchronous reset between edges with data in flight.
        do_clr();
        out_ready = 1'b0;
        acc_valid = 1'b1; acc_in = SW'(100000); shift = 4'd0;
        tick();
        acc_in = SW'(40); shift = 4'd2;
        tick();
        acc_valid = 1'b0;
        tick();
        #2 rst = 1'b0;
        #1;
        check("arst.out_valid", out_valid, 0);
        check("arst.out_data", out_data, 0);
        check("arst.sat", sat_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("arst.no_stale", out_valid, 0);
        run_vec("arst.after", -6, 0, 2, RELU ? 0 : -1, 0);

        // Randomized traffic checked against an ordered queue of model results.
        do_clr();
        exp_sat = 0;
        hold = 1'b0;
        prev_data = '0;
        for (int c = 0; c < 2000; c++) begin
            acc_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                a = int'($urandom_range(0, 1048575)) - 524288;
                b = int'($urandom_range(0, 1048575)) - 524288;
            end else begin
                a = int'($urandom_range(0, 8000)) - 4000;
                b = int'($urandom_range(0, 400)) - 200;
            end
            s = int'($urandom_range(0, 15));
            acc_in = SW'(a); bias = SW'(b); shift = 4'(s);
            #1;
            if (hold) check("rnd.hold", out_data, prev_data);
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("rnd.unexpected", out_valid, 0);
                else check("rnd.data", out_data, q.pop_front());
            end
            hold = out_valid && !out_ready;
            prev_data = out_data;
            if (acc_valid && in_ready) begin
                e = model(a, b, s, cl);
                q.push_back(e);
                if (cl && exp_sat < 255) exp_sat++;
            end
            check("rnd.fifo_bound", dut.u_fifo.count <= DEPTH, 1);
            tick();
        end
        acc_valid = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            #1;
            if (out_valid) check("rnd.drain", out_data, q.pop_front());
            tick();
            guard++;
        end
        check("rnd.drained", q.size(), 0);
        check("rnd.sat", sat_cnt, exp_sat);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_drain.md
Name: mac_drain

Overview:
- Output-side reader for the MAC systolic column; it consumes the accumulated partial sum leaving the last mac_unit stage.
- Adds a per-channel bias, applies rounding arithmetic shift, optional ReLU and saturation to n-bit activations.
- Buffers results in a small FIFO and streams them to the next CNN layer with a valid/ready handshake.
- Sits between the systolic column output and the activation write-back path.

Parameters:
- n, 8, activation/output data width
- SUM_WIDTH, (n*2)+4, accumulator width; matches mac_unit
- DEPTH, 4, output FIFO depth in entries; power of two, ≥2

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- clr  input  1  synchronous flush of pipeline, FIFO and sat_cnt
- acc_valid  input  1  acc_in holds a finished sum
- acc_in  input  SUM_WIDTH  signed accumulated sum from the MAC column
- in_ready  output  1  drain can accept acc_in this cycle
- bias  input  SUM_WIDTH  signed bias, sampled with acc_in
- shift  input  4  requantisation right-shift (0..15), sampled with acc_in
- out_valid  output  1  out_data valid (FIFO non-empty)
- out_data  output  n  signed quantised activation (FIFO head)
- out_ready  input  1  downstream accepts out_data
- sat_cnt  output  8  saturating count of clipped results

Behaviour:
- Reset (rst=0, async):
  - Stage A is empty and the FIFO is empty.
  - out_valid=0, out_data=0, sat_cnt=0; in_ready=1 once rst deasserts.
  - Reset mid-operation discards all in-flight data.
- Accept: a transfer occurs on the edge where acc_valid && in_ready.
  - in_ready = !clr && (fifo_count + stageA_valid) <= DEPTH-1.
  - in_ready depends on registers and clr only; it never depends on out_ready or acc_valid.
- Stage A (registered at accept edge k): sum = acc_in + bias as SUM_WIDTH+1 signed (no overflow possible); shift is captured alongside.
- Stage B (combinational from stage A, written to FIFO at edge k+1):
  - r = (sum + (shift>0 ? 2^(shift-1) : 0)) >>> shift. This is arithmetic shift, round half toward +inf.
  - Saturate r to [-2^(n-1), 2^(n-1)-1]. Any clip increments sat_cnt, which holds at 255.
- Latency: value accepted at edge k appears on out_data with out_valid=1 after edge k+1 when the FIFO was empty.
- Output:
  - A pop occurs on an edge with out_valid && out_ready.
  - out_data shows the FIFO head and is stable while out_valid && !out_ready.
  - Order is preserved.
- Simultaneous push and pop in the same edge are allowed at any fill level, including full; count is unchanged.
- FIFO pointers wrap modulo DEPTH; count range is 0..DEPTH. Overflow is impossible because of the in_ready rule, and the bench asserts it.
- clr=1:
  - Next edge empties stage A and the FIFO and zeroes sat_cnt; out_valid=0 after that edge.
  - in_ready=0 during clr, so an acc_valid presented in the same cycle is not accepted.
  - clr has priority over push and pop.

Optional Feature:
- Macro: MAC_DRAIN_RELU_EN.
- Defined:
  - Stage B forces r<0 to 0 before saturation.
  - Range becomes [0, 2^(n-1)-1]; ReLU zeroing does not count as saturation.
- Undefined: signed saturation only, as above.

Decomposition:
- Package mac_pkg:
  - default n and SUM_WIDTH, shared with mac_unit
  - SHIFT_W=4
  - ACT_MAX/ACT_MIN saturation constants
  - sat_cnt width
- One sub-module: drain_fifo, a synchronous FIFO with DEPTH entries, count output, show-ahead read and push/pop.

Test Plan (n=8, SUM_WIDTH=20, DEPTH=4):
- acc_in=200, bias=-8, shift=2, out_ready=1 → out_data=48 (192+2=194>>2), out_valid exactly 2 edges after accept, sat_cnt=0.
- acc_in=-6, bias=0, shift=2 → -1 (relu off) / 0 (relu on); acc_in=-500, shift=0 → -128, sat_cnt=1 (relu off) / 0, sat_cnt=0 (relu on).
- acc_in=1000, bias=24, shift=3 → 1028>>3=128 clipped to 127, sat_cnt=1.
- out_ready=0, six back-to-back acc_valid with acc_in=4,8,12,16,20,24 and shift=2 → only 1,2,3,4 accepted, in_ready=0 thereafter.
  - Then out_ready=1 → outputs 1,2,3,4 in order; in_ready reasserts after the first pop.
- Stream with FIFO at 2 entries, assert clr with acc_valid=1 → that input not accepted, out_valid=0 and sat_cnt=0 after the edge.
  - Next transfer behaves as from reset.
- 300 saturating inputs → sat_cnt holds 255.
- Drop rst mid-stream between edges → outputs zero immediately without a clock edge; no stale data after release.
